// File: rtl/demux_serial_driver.sv
`default_nettype none
// ============================================================================
// Module   : demux_serial_driver
// Brief    : Serializes one parallel word per valid/ready handshake onto din,
//            MSB first, holding the 1-to-2 demux select s stable for the whole
//            frame. Bits are qualified with bit_valid and frame markers, and
//            an optional idle gap with din low follows every frame.
// Revision : 1.0 - initial release
// ============================================================================
module demux_serial_driver #(
    parameter int WIDTH      = 8,   // bits per frame, 2..16
    parameter int GAP_CYCLES = 1    // idle cycles after each frame, 0..15
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic             in_ch_i,
    output logic             din_o,
    output logic             s_o,
    output logic             bit_valid_o,
    output logic             frame_start_o,
    output logic             frame_end_o,
    output logic             busy_o
);

    // One 4-bit counter serves both the bit countdown (max WIDTH-1 = 15)
    // and the gap countdown (max GAP_CYCLES-1 = 14).
    localparam int unsigned c_CNT_W = 4;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_SHIFT = 2'd1;
    localparam logic [1:0] c_ST_GAP   = 2'd2;

    localparam logic [c_CNT_W-1:0] c_BIT_LOAD = 4'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    logic [1:0]         state_q, state_d;
    logic [c_CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]   sh_q, sh_d;
    logic               s_q, s_d;

    logic               in_ready_q, in_ready_d;
    logic               din_q, din_d;
    logic               bit_valid_q, bit_valid_d;
    logic               frame_start_q, frame_start_d;
    logic               frame_end_q, frame_end_d;
    logic               busy_q, busy_d;

    logic               w_accept;

    // in_ready_q is low for the first cycle after reset, so it gates accept too.
    assign w_accept = (state_q == c_ST_IDLE) && in_valid_i && in_ready_q;

    // State register: FSM state, datapath and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= c_ST_IDLE;
            cnt_q         <= '0;
            sh_q          <= '0;
            s_q           <= 1'b0;
            in_ready_q    <= 1'b0;
            din_q         <= 1'b0;
            bit_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            sh_q          <= sh_d;
            s_q           <= s_d;
            in_ready_q    <= in_ready_d;
            din_q         <= din_d;
            bit_valid_q   <= bit_valid_d;
            frame_start_q <= frame_start_d;
            frame_end_q   <= frame_end_d;
            busy_q        <= busy_d;
        end
    end

    // Next-state logic: accept, bit countdown, optional gap, return to idle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        s_d     = s_q;
        case (state_q)
            c_ST_IDLE: begin
                if (w_accept) begin
                    state_d = c_ST_SHIFT;
                    cnt_d   = c_BIT_LOAD;
                    sh_d    = in_data_i;
                    s_d     = in_ch_i;
                end
            end
            c_ST_SHIFT: begin
                sh_d = {sh_q[WIDTH-2:0], 1'b0};
                if (cnt_q == '0) begin
                    state_d = (GAP_CYCLES == 0) ? c_ST_IDLE : c_ST_GAP;
                    cnt_d   = c_GAP_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            c_ST_GAP: begin
                if (cnt_q == '0) begin
                    state_d = c_ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = c_ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output logic: derive next-cycle outputs from the next state so every
    // output comes straight from a flop; din is forced low outside SHIFT.
    always_comb begin
        in_ready_d    = (state_d == c_ST_IDLE);
        busy_d        = (state_d != c_ST_IDLE);
        bit_valid_d   = (state_d == c_ST_SHIFT);
        din_d         = bit_valid_d & sh_d[WIDTH-1];
        frame_start_d = bit_valid_d && (state_q != c_ST_SHIFT);
        frame_end_d   = bit_valid_d && (cnt_d == '0);
    end

    assign in_ready_o    = in_ready_q;
    assign din_o         = din_q;
    assign s_o           = s_q;
    assign bit_valid_o   = bit_valid_q;
    assign frame_start_o = frame_start_q;
    assign frame_end_o   = frame_end_q;
    assign busy_o        = busy_q;

endmodule
`default_nettype wire
